// File: rtl/uart_tx_par.sv
// UART transmitter with selectable parity (none/odd/even/mark), LSB first, registered tx.
// Optional two-stop-bit support is enabled by defining UART_TX_PAR_STOP2_EN.
module uart_tx_par #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic              in_valid,
`ifdef UART_TX_PAR_STOP2_EN
  input  logic              stop2,
`endif
  output logic              in_ready,
  output logic              tx,
  output logic              parity_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               par_q, par_d;
  logic               haspar_q, haspar_d;
  logic               tx_q, tx_d;
  logic               live_q;
  logic               bit_end, stop_last, accept, par_calc;
`ifdef UART_TX_PAR_STOP2_EN
  logic               stop2_q, stop2_d;
  logic               sb_q, sb_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);
`ifdef UART_TX_PAR_STOP2_EN
  assign stop_last = bit_end && (sb_q == stop2_q);
`else
  assign stop_last = bit_end;
`endif

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready   = live_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_last));
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign parity_out = par_q;

  always_comb begin
    par_calc = 1'b0;
    case (parity_type)
      2'b01:   par_calc = ~^data_in;
      2'b10:   par_calc = ^data_in;
      2'b11:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    haspar_d = haspar_q;
    tx_d     = tx_q;
`ifdef UART_TX_PAR_STOP2_EN
    stop2_d  = stop2_q;
    sb_d     = sb_q;
`endif
    if (accept) begin
      data_d   = data_in;
      par_d    = par_calc;
      haspar_d = (parity_type != 2'b00);
`ifdef UART_TX_PAR_STOP2_EN
      stop2_d  = stop2;
`endif
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        // data_q shifts right so the current bit is always at [0]
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = haspar_q ? S_PARITY : S_STOP;
            tx_d    = haspar_q ? par_q : 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
`ifdef UART_TX_PAR_STOP2_EN
        if (bit_end && !stop_last) sb_d = 1'b1;
`endif
        if (stop_last) begin
`ifdef UART_TX_PAR_STOP2_EN
          sb_d = 1'b0;
`endif
          if (accept) begin
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      haspar_q <= 1'b0;
      tx_q     <= 1'b1;
      live_q   <= 1'b0;
`ifdef UART_TX_PAR_STOP2_EN
      stop2_q  <= 1'b0;
      sb_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      haspar_q <= haspar_d;
      tx_q     <= tx_d;
      live_q   <= 1'b1;
`ifdef UART_TX_PAR_STOP2_EN
      stop2_q  <= stop2_d;
      sb_q     <= sb_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_par.sv
// Randomized bench for uart_tx_par against a per-cycle expected line model built from frame rules.
module tb_uart_tx_par;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [1:0]    parity_type = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, parity_out, busy;

  always #5 clk = ~clk;

  uart_tx_par #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .parity_type(parity_type),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx),
    .parity_out(parity_out), .busy(busy)
  );

  typedef struct {
    logic tx;
    logic par;
    logic rdy;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // parity bit from the count of ones: odd mode makes the total odd, even mode keeps it even
  function automatic logic model_par(input logic [DW-1:0] d, input logic [1:0] m);
    int ones = $countones(d);
    case (m)
      2'd1:    return (ones % 2) == 0;
      2'd2:    return (ones % 2) == 1;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int frame_len(input logic [1:0] m);
    return CPB * (DW + 2 + ((m != 2'd0) ? 1 : 0));
  endfunction

  task automatic push_frame(input logic [DW-1:0] d, input logic [1:0] m);
    logic bits[$];
    logic p;
    cyc_t c;
    p = model_par(d, m);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (m != 2'd0) bits.push_back(p);
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int k = 0; k < CPB; k++) begin
        c.tx  = bits[b];
        c.par = p;
        c.rdy = (b == bits.size() - 1) && (k == CPB - 1);
        exp_q.push_back(c);
      end
  endtask

  task automatic scramble_drop();
    in_valid    = 1'b0;
    data_in     = DW'($urandom);
    parity_type = 2'($urandom);
  endtask

  // pops n expected cycles; hold>0 keeps in_valid high with a second word until cycle hold
  task automatic run(input int n, input int hold, input logic [DW-1:0] d2, input logic [1:0] m2);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c = exp_q.pop_front();
      chk("tx", 32'(tx), 32'(c.tx));
      chk("parity_out", 32'(parity_out), 32'(c.par));
      chk("busy", 32'(busy), 32'd1);
      chk("in_ready", 32'(in_ready), 32'(c.rdy));
      if (k == 0 && hold > 0) begin
        data_in     = d2;
        parity_type = m2;
      end else if (k == hold) begin
        scramble_drop();
      end
    end
  endtask

  task automatic start_word(input logic [DW-1:0] d, input logic [1:0] m, output bit ok);
    int t = 0;
    @(negedge clk);
    data_in = d; parity_type = m; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m,
                      input bit b2b, input logic [DW-1:0] d2, input logic [1:0] m2);
    bit ok;
    push_frame(d, m);
    if (b2b) push_frame(d2, m2);
    start_word(d, m, ok);
    if (ok) begin
      run(exp_q.size(), b2b ? frame_len(m) : 0, d2, m2);
      check_idle();
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    m;
  } vec_t;

  vec_t dir[7];

  initial begin
    bit ok;
    logic [DW-1:0] rd, rd2;
    logic [1:0]    rm, rm2;

    // reset held with a pending word: line idle, nothing accepted
    in_valid = 1'b1; data_in = 8'hA5; parity_type = 2'd2;
    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_par", 32'(parity_out), 32'd0);
    end
    rst = 1'b1; in_valid = 1'b0;
    #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    dir[0] = '{8'h01, 2'd2}; dir[1] = '{8'h03, 2'd2}; dir[2] = '{8'hFF, 2'd2};
    dir[3] = '{8'h00, 2'd1}; dir[4] = '{8'hFF, 2'd1}; dir[5] = '{8'h03, 2'd3};
    dir[6] = '{8'hA5, 2'd0};
    foreach (dir[i]) send(dir[i].d, dir[i].m, 1'b0, '0, 2'd0);

    // back-to-back with in_valid held high
    send(8'h55, 2'd2, 1'b1, 8'h0F, 2'd2);

    // reset during DATA bit 3 aborts the frame
    push_frame(8'h5A, 2'd1);
    start_word(8'h5A, 2'd1, ok);
    if (ok) begin
      run(CPB * 4 + 1, 0, '0, 2'd0);
      #2 rst = 1'b0;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd0);
      chk("abort_par", 32'(parity_out), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      check_idle();
      send(8'hC3, 2'd2, 1'b0, '0, 2'd0);
    end

    for (int i = 0; i < 30; i++) begin
      rd = DW'($urandom); rm = 2'($urandom);
      rd2 = DW'($urandom); rm2 = 2'($urandom);
      send(rd, rm, ($urandom_range(0, 3) == 0), rd2, rm2);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_par.md
UART_TX_PAR -- requirements
Module: uart_tx_par

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  DATA_W  word to transmit, LSB first.
REQ-006 SHALL have port parity_type  input  2  parity mode: 00 none, 01 odd, 10 even, 11 mark (bit forced 1).
REQ-007 SHALL have port in_valid  input  1  data_in/parity_type valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port parity_out  output  1  parity bit of the word in flight; 0 when mode 00.
REQ-011 SHALL have port busy  output  1  frame in progress.

Function
REQ-012 SHALL accept a word when in_valid and in_ready are both high on a clk edge, latching data_in and parity_type at that edge.
REQ-013 SHALL ignore data_in/parity_type changes after acceptance until the next acceptance.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL transition IDLE->START on acceptance; START->DATA, DATA->PARITY (mode != 00) or DATA->STOP (mode 00), PARITY->STOP, each after CLKS_PER_BIT cycles.
REQ-016 SHALL leave DATA after exactly DATA_W bit periods, with a bit index running 0..DATA_W-1.
REQ-017 SHALL transition STOP->IDLE after the last stop-bit period, or STOP->START if a word is accepted in its final cycle.
REQ-018 SHALL drive tx from a register: 0 in START, data bit[index] in DATA, parity_out in PARITY, 1 in STOP and IDLE.
REQ-019 SHALL drive tx low on the first cycle after the acceptance edge (1-cycle latency); every bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-020 SHALL compute parity_out at acceptance: odd = ~^data, even = ^data, mark = 1, none = 0; held until the next acceptance.
REQ-021 SHALL assert in_ready in IDLE and in the final cycle of the last stop bit; otherwise low.
REQ-022 SHALL assert busy in every state other than IDLE.
REQ-023 SHALL produce back-to-back frames with no idle gap when in_valid is held high.
REQ-024 SHALL use a baud counter of width clog2(CLKS_PER_BIT) counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.

Reset
REQ-025 SHALL on rst low immediately force IDLE, tx=1, busy=0, in_ready=0, parity_out=0, and clear the counters and data register.
REQ-026 SHALL abort a frame in progress when reset asserts mid-frame; no partial frame SHALL resume.
REQ-027 SHALL raise in_ready on the first clk edge after rst deasserts.

Configuration
REQ-028 SHALL use macro UART_TX_PAR_STOP2_EN to gate two-stop-bit support.
REQ-029 With UART_TX_PAR_STOP2_EN defined, SHALL add port stop2 (input, 1), latched at acceptance; when 1, STOP lasts 2*CLKS_PER_BIT cycles.
REQ-030 Without UART_TX_PAR_STOP2_EN, SHALL omit port stop2 and fix STOP at CLKS_PER_BIT cycles.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-031 SHALL cover: rst low with in_valid=1 -> tx=1, busy=0, in_ready=0 throughout; in_ready=1 one edge after release.
REQ-032 SHALL cover: 0x01, mode 10 -> parity_out=1; tx = 0,1,0,0,0,0,0,0,0,1,1, each bit 4 cycles, 44 cycles total.
REQ-033 SHALL cover: 0x03 mode 10 -> parity 0; 0xFF mode 10 -> 0; 0x00 mode 01 -> 1; 0xFF mode 01 -> 1; 0x03 mode 11 -> 1.
REQ-034 SHALL cover: 0xA5, mode 00 -> no parity bit; frame is 40 cycles, parity_out=0.
REQ-035 SHALL cover: in_valid held high for 0x55 then 0x0F -> second start bit begins on the cycle after the first stop bit ends; busy never drops.
REQ-036 SHALL cover: rst pulsed low during DATA bit 3 -> tx=1 immediately; the next accepted word transmits a complete, correct frame.
